// File: rtl/ltc2387_acq_ctrl_if.sv
// Signal bundle between the LTC2387 acquisition controller (master) and the
// ADC pins plus the sample consumer (slave).
interface ltc2387_acq_ctrl_if #(
  parameter int ADC_WIDTH = 18
);
  logic                 enable;
  logic [15:0]          period;
  logic                 da;
  logic                 db;
  logic                 cnv;
  logic                 adc_clk;
  logic [ADC_WIDTH-1:0] sample_data;
  logic                 sample_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    input  enable, period, da, db,
    output cnv, adc_clk, sample_data, sample_valid, busy, overrun
  );

  modport slave (
    output enable, period, da, db,
    input  cnv, adc_clk, sample_data, sample_valid, busy, overrun
  );
endinterface

// File: rtl/ltc2387_acq_ctrl.sv
// LTC2387 acquisition scheduler: periodic CNV pulse, conversion wait, then a
// gated adc_clk burst that deserialises the two DDR lanes into one sample.
module ltc2387_acq_ctrl #(
  parameter int ADC_WIDTH        = 18,
  parameter int CLK_HALF_PERIOD  = 2,
  parameter int CNV_HIGH_CYCLES  = 2,
  parameter int CONV_WAIT_CYCLES = 8,
  parameter int NUM_CLK_PULSES   = 5
) (
  input  logic clk,
  input  logic reset,
  ltc2387_acq_ctrl_if.master bus
);

  localparam int CYC_W  = $clog2(CONV_WAIT_CYCLES + 1);
  localparam int HALF_W = $clog2(CLK_HALF_PERIOD + 1);
  localparam int EDGE_W = $clog2(2 * NUM_CLK_PULSES + 1);

  localparam logic [CYC_W-1:0]  CNV_END     = CYC_W'(CNV_HIGH_CYCLES);
  localparam logic [CYC_W-1:0]  WAIT_END    = CYC_W'(CONV_WAIT_CYCLES);
  localparam logic [HALF_W-1:0] HALF_END    = HALF_W'(CLK_HALF_PERIOD);
  localparam logic [EDGE_W-1:0] NUM_SAMPLES = EDGE_W'(ADC_WIDTH / 2);
  localparam logic [EDGE_W-1:0] LAST_SAMPLE = EDGE_W'(ADC_WIDTH / 2 - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE   = EDGE_W'(2 * NUM_CLK_PULSES - 1);

  typedef enum logic [1:0] {IDLE, CNV_HI, CONV_WAIT, CLOCKING} state_t;

  state_t                state_reg, state_next;
  logic [15:0]           period_cnt_reg, period_cnt_next;
  logic [CYC_W-1:0]      cyc_reg, cyc_next;
  logic [HALF_W-1:0]     half_reg, half_next;
  logic [EDGE_W-1:0]     edge_reg, edge_next;
  logic [ADC_WIDTH-1:0]  shift_reg, shift_next;
  logic [ADC_WIDTH-1:0]  sample_data_reg, sample_data_next;
  logic                  cnv_reg, cnv_next;
  logic                  adc_clk_reg, adc_clk_next;
  logic                  sample_valid_reg, sample_valid_next;
  logic                  busy_reg, busy_next;
  logic                  overrun_reg, overrun_next;

  logic                  trigger;
  logic [ADC_WIDTH-1:0]  shifted;

  // Trigger is judged on pre-edge counter and busy values.
  assign trigger = bus.enable && (period_cnt_reg == 16'd0);
  assign shifted = {shift_reg[ADC_WIDTH-3:0], bus.da, bus.db};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      period_cnt_reg   <= '0;
      cyc_reg          <= '0;
      half_reg         <= '0;
      edge_reg         <= '0;
      shift_reg        <= '0;
      sample_data_reg  <= '0;
      cnv_reg          <= 1'b0;
      adc_clk_reg      <= 1'b0;
      sample_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      period_cnt_reg   <= period_cnt_next;
      cyc_reg          <= cyc_next;
      half_reg         <= half_next;
      edge_reg         <= edge_next;
      shift_reg        <= shift_next;
      sample_data_reg  <= sample_data_next;
      cnv_reg          <= cnv_next;
      adc_clk_reg      <= adc_clk_next;
      sample_valid_reg <= sample_valid_next;
      busy_reg         <= busy_next;
      overrun_reg      <= overrun_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    period_cnt_next   = period_cnt_reg;
    cyc_next          = cyc_reg;
    half_next         = half_reg;
    edge_next         = edge_reg;
    shift_next        = shift_reg;
    sample_data_next  = sample_data_reg;
    cnv_next          = cnv_reg;
    adc_clk_next      = adc_clk_reg;
    sample_valid_next = 1'b0;
    busy_next         = busy_reg;
    overrun_next      = overrun_reg;

    // period of 0 or 1 reloads 0, so every enabled cycle triggers
    if (!bus.enable) begin
      period_cnt_next = 16'd0;
    end else if (period_cnt_reg == 16'd0) begin
      period_cnt_next = (bus.period > 16'd1) ? (bus.period - 16'd1) : 16'd0;
    end else begin
      period_cnt_next = period_cnt_reg - 16'd1;
    end

    if (trigger && busy_reg) begin
      overrun_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          state_next = CNV_HI;
          cnv_next   = 1'b1;
          busy_next  = 1'b1;
          cyc_next   = CYC_W'(1);
        end
      end
      CNV_HI: begin
        cyc_next = cyc_reg + CYC_W'(1);
        if (cyc_reg == CNV_END) begin
          cnv_next   = 1'b0;
          state_next = CONV_WAIT;
        end
      end
      CONV_WAIT: begin
        cyc_next = cyc_reg + CYC_W'(1);
        if (cyc_reg == WAIT_END) begin
          state_next   = CLOCKING;
          half_next    = HALF_W'(1);
          edge_next    = '0;
          adc_clk_next = 1'b0;
        end
      end
      CLOCKING: begin
        if (half_reg == HALF_END) begin
          half_next    = HALF_W'(1);
          adc_clk_next = ~adc_clk_reg;
          edge_next    = edge_reg + EDGE_W'(1);
          if (edge_reg < NUM_SAMPLES) begin
            shift_next = shifted;
          end
          if (edge_reg == LAST_SAMPLE) begin
            sample_data_next  = shifted;
            sample_valid_next = 1'b1;
          end
          if (edge_reg == LAST_EDGE) begin
            adc_clk_next = 1'b0;
            busy_next    = 1'b0;
            state_next   = IDLE;
          end
        end else begin
          half_next = half_reg + HALF_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.cnv          = cnv_reg;
  assign bus.adc_clk      = adc_clk_reg;
  assign bus.sample_data  = sample_data_reg;
  assign bus.sample_valid = sample_valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_ltc2387_acq_ctrl.sv
// Directed bench for ltc2387_acq_ctrl with default parameters; expected timing
// is written relative to the trigger edge T0 (sampled 1 time unit after edges).
module tb_ltc2387_acq_ctrl;

  localparam int W        = 18;
  localparam int CNV_HI   = 2;
  localparam int WAIT     = 8;
  localparam int HALF     = 2;
  localparam int PULSES   = 5;
  localparam int FIRST_E  = WAIT + HALF;                 // edge 0 at T0+10
  localparam int END_E    = WAIT + HALF * 2 * PULSES;    // last edge at T0+28
  localparam int VALID_K  = WAIT + HALF * (W / 2);       // last sample edge T0+26

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ltc2387_acq_ctrl_if #(.ADC_WIDTH(W)) bus ();

  ltc2387_acq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_aclk(input int k);
    if (k < FIRST_E || k >= END_E) return 1'b0;
    return (((k - FIRST_E) / HALF) % 2) == 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_value({tag, " cnv"},          32'(bus.cnv),          32'd0);
    check_value({tag, " adc_clk"},      32'(bus.adc_clk),      32'd0);
    check_value({tag, " sample_data"},  32'(bus.sample_data),  32'd0);
    check_value({tag, " sample_valid"}, 32'(bus.sample_valid), 32'd0);
    check_value({tag, " busy"},         32'(bus.busy),         32'd0);
    check_value({tag, " overrun"},      32'(bus.overrun),      32'd0);
  endtask

  task automatic do_reset;
    bus.enable = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();
  endtask

  // Called just after edge T0; walks T0+1..T0+28 checking every cycle.
  task automatic check_seq(input string name, input logic [W-1:0] exp_data, input int drop_at);
    check_value({name, " T0 cnv"},  32'(bus.cnv),  32'd1);
    check_value({name, " T0 busy"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k <= END_E; k++) begin
      tick();
      if (k == drop_at) bus.enable = 1'b0;
      check_value($sformatf("%s cnv k=%0d", name, k),     32'(bus.cnv),          32'(k < CNV_HI));
      check_value($sformatf("%s busy k=%0d", name, k),    32'(bus.busy),         32'(k < END_E));
      check_value($sformatf("%s adc_clk k=%0d", name, k), 32'(bus.adc_clk),      32'(exp_aclk(k)));
      check_value($sformatf("%s valid k=%0d", name, k),   32'(bus.sample_valid), 32'(k == VALID_K));
      if (k == VALID_K || k == VALID_K + 1)
        check_value($sformatf("%s data k=%0d", name, k), 32'(bus.sample_data), 32'(exp_data));
    end
    $display("tb: %s sequence done, sample_data=0x%0h", name, bus.sample_data);
  endtask

  initial begin
    logic [W-1:0] pat;
    int idx;
    logic last_aclk;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.period = 16'd0;
    bus.da = 1'b0;
    bus.db = 1'b0;
    #1;

    // basic period-40 run, reset mid-sequence, enable drop
    do_reset();
    bus.period = 16'd40;
    bus.da = 1'b1;
    bus.db = 1'b0;
    bus.enable = 1'b1;
    tick();
    check_seq("p40", 18'h2AAAA, 0);
    for (int k = END_E + 1; k < 40; k++) begin
      tick();
      check_value($sformatf("p40 gap cnv k=%0d", k), 32'(bus.cnv), 32'd0);
    end
    tick();
    check_value("p40 next cnv at T0+40", 32'(bus.cnv), 32'd1);
    repeat (14) tick();
    check_value("pre-reset adc_clk", 32'(bus.adc_clk), 32'd1);
    check_value("pre-reset busy", 32'(bus.busy), 32'd1);
    check_value("pre-reset data", 32'(bus.sample_data), 32'h2AAAA);
    reset = 1'b1;
    #1;
    check_idle_outputs("async reset");
    for (int k = 0; k < 15; k++) begin
      tick();
      check_value($sformatf("in reset valid c=%0d", k), 32'(bus.sample_valid), 32'd0);
      check_value($sformatf("in reset cnv c=%0d", k),   32'(bus.cnv),          32'd0);
    end
    reset = 1'b0;
    tick();
    check_seq("post-reset", 18'h2AAAA, 5);
    for (int k = 0; k < 40; k++) begin
      tick();
      check_value($sformatf("disabled cnv c=%0d", k),     32'(bus.cnv),     32'd0);
      check_value($sformatf("disabled adc_clk c=%0d", k), 32'(bus.adc_clk), 32'd0);
      check_value($sformatf("disabled busy c=%0d", k),    32'(bus.busy),    32'd0);
    end

    // back-to-back at minimum period 29
    do_reset();
    bus.period = 16'd29;
    bus.da = 1'b1;
    bus.db = 1'b1;
    bus.enable = 1'b1;
    tick();
    check_seq("p29 first", 18'h3FFFF, 0);
    tick();
    check_seq("p29 second", 18'h3FFFF, 0);
    check_value("p29 overrun", 32'(bus.overrun), 32'd0);

    // period 28: second trigger skipped, overrun sticky
    do_reset();
    bus.period = 16'd28;
    bus.da = 1'b0;
    bus.db = 1'b1;
    bus.enable = 1'b1;
    tick();
    check_seq("p28 first", 18'h15555, 0);
    check_value("p28 overrun set", 32'(bus.overrun), 32'd1);
    for (int k = END_E + 1; k < 56; k++) begin
      tick();
      check_value($sformatf("p28 skip cnv k=%0d", k), 32'(bus.cnv), 32'd0);
    end
    tick();
    check_value("p28 overrun sticky", 32'(bus.overrun), 32'd1);
    check_seq("p28 third", 18'h15555, 0);
    check_value("p28 overrun still", 32'(bus.overrun), 32'd1);

    // lane pattern changing on each adc_clk edge
    do_reset();
    pat = 18'b110011001100110011;
    bus.period = 16'd100;
    idx = 0;
    bus.da = pat[W-1];
    bus.db = pat[W-2];
    bus.enable = 1'b1;
    tick();
    check_value("pattern T0 cnv", 32'(bus.cnv), 32'd1);
    last_aclk = bus.adc_clk;
    for (int k = 1; k <= END_E; k++) begin
      tick();
      if (bus.adc_clk != last_aclk) begin
        idx++;
        if (idx < W / 2) begin
          bus.da = pat[W - 1 - 2 * idx];
          bus.db = pat[W - 2 - 2 * idx];
        end
      end
      last_aclk = bus.adc_clk;
      if (k == VALID_K) begin
        check_value("pattern valid", 32'(bus.sample_valid), 32'd1);
        check_value("pattern data", 32'(bus.sample_data), 32'h33333);
      end
    end
    check_value("pattern edge count", 32'(idx), 32'(2 * PULSES));
    $display("tb: pattern sequence done, sample_data=0x%0h", bus.sample_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
